// File: rtl/mem_access_guard_if.sv
// Bus between the MEM stage/CP0 side and the access guard: request, verdict,
// held-exception and counter signals.
interface mem_access_guard_if #(
  parameter int unsigned CNT_W = 8
);
  logic             req_valid;
  logic [31:0]      req_addr;
  logic [3:0]       req_code;
  logic [31:0]      req_pc;
  logic             flush;
  logic             chk_valid;
  logic             chk_fault;
  logic             chk_dev;
  logic             exc_pending;
  logic [4:0]       exc_code;
  logic [31:0]      exc_badvaddr;
  logic [31:0]      exc_epc;
  logic             exc_ack;
  logic [CNT_W-1:0] fault_cnt;
  logic [CNT_W-1:0] drop_cnt;

  modport master (
    output req_valid, req_addr, req_code, req_pc, flush, exc_ack,
    input  chk_valid, chk_fault, chk_dev, exc_pending, exc_code,
           exc_badvaddr, exc_epc, fault_cnt, drop_cnt
  );

  modport slave (
    input  req_valid, req_addr, req_code, req_pc, flush, exc_ack,
    output chk_valid, chk_fault, chk_dev, exc_pending, exc_code,
           exc_badvaddr, exc_epc, fault_cnt, drop_cnt
  );
endinterface

// File: rtl/mem_access_guard.sv
// Data-memory access guard: classifies MEM-stage accesses against the DM and device
// windows, registers the verdict and holds the first unacknowledged fault for CP0.
module mem_access_guard #(
  parameter logic [31:0]         DM_LIMIT   = 32'h0000_2FFF,
  parameter int unsigned         N_DEV      = 2,
  parameter logic [N_DEV*32-1:0] DEV_BASE   = {32'h7F10, 32'h7F00},
  parameter int unsigned         DEV_SPAN   = 12,
  parameter int unsigned         DEV_RO_OFS = 8,
  parameter int unsigned         CNT_W      = 8
) (
  input logic               clk,
  input logic               reset_n,
  mem_access_guard_if.slave bus
);
  localparam logic [0:0]       EMPTY    = 1'b0;
  localparam logic [0:0]       HELD     = 1'b1;
  localparam logic [4:0]       EXC_ADEL = 5'd4;
  localparam logic [4:0]       EXC_ADES = 5'd5;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic        is_word_c, is_half_c, is_byte_c, is_store_c, is_access_c;
  logic        in_dm_c, in_dev_c, ro_hit_c, fault_c, stage_en_c;
  logic [32:0] addr_x, base_x;

  logic             chk_valid_q, chk_fault_q, chk_dev_q, stg_store_q;
  logic [31:0]      stg_addr_q, stg_pc_q;
  logic [0:0]       state_q, state_d;
  logic             new_fault_c, capture_c, drop_c;
  logic [4:0]       exc_code_q;
  logic [31:0]      exc_badvaddr_q, exc_epc_q;
  logic [CNT_W-1:0] fault_cnt_q, drop_cnt_q;

  // Request classification; 33-bit compares keep window ends from wrapping.
  always_comb begin : classify
    is_word_c  = 1'b0;
    is_half_c  = 1'b0;
    is_byte_c  = 1'b0;
    is_store_c = 1'b0;
    case (bus.req_code)
      4'd0: is_word_c = 1'b1;
      4'd1: begin is_word_c = 1'b1; is_store_c = 1'b1; end
      4'd2, 4'd4: is_half_c = 1'b1;
      4'd6: begin is_half_c = 1'b1; is_store_c = 1'b1; end
      4'd3, 4'd5: is_byte_c = 1'b1;
      4'd7: begin is_byte_c = 1'b1; is_store_c = 1'b1; end
      default: ;
    endcase
    is_access_c = is_word_c | is_half_c | is_byte_c;
    addr_x  = {1'b0, bus.req_addr};
    in_dm_c = is_word_c ? (addr_x + 33'd3 <= {1'b0, DM_LIMIT}) : (addr_x <= {1'b0, DM_LIMIT});
    base_x   = '0;
    in_dev_c = 1'b0;
    ro_hit_c = 1'b0;
    for (int unsigned i = 0; i < N_DEV; i++) begin
      base_x = {1'b0, DEV_BASE[32*i +: 32]};
      if (addr_x >= base_x && addr_x <= base_x + 33'(DEV_SPAN) - 33'd1) in_dev_c = 1'b1;
      if (addr_x == base_x + 33'(DEV_RO_OFS)) ro_hit_c = 1'b1;
    end
    fault_c = is_access_c & ((is_word_c & (bus.req_addr[1:0] != 2'b00)) |
                             (is_half_c & bus.req_addr[0]) |
                             (~in_dm_c & ~in_dev_c) |
                             (~is_word_c & in_dev_c) |
                             (is_store_c & ro_hit_c));
    stage_en_c = bus.req_valid & is_access_c & ~bus.flush;
  end

  always_ff @(posedge clk or negedge reset_n) begin : stage_reg
    if (!reset_n) begin
      chk_valid_q <= 1'b0;
      chk_fault_q <= 1'b0;
      chk_dev_q   <= 1'b0;
      stg_store_q <= 1'b0;
      stg_addr_q  <= '0;
      stg_pc_q    <= '0;
    end else begin
      chk_valid_q <= stage_en_c;
      chk_fault_q <= stage_en_c & fault_c;
      chk_dev_q   <= stage_en_c & in_dev_c & ~fault_c;
      stg_store_q <= is_store_c;
      stg_addr_q  <= bus.req_addr;
      stg_pc_q    <= bus.req_pc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin : hold_state
    if (!reset_n) state_q <= EMPTY;
    else          state_q <= state_d;
  end

  // An ack in the same cycle as a new fault frees the slot for that fault.
  always_comb begin : hold_fsm
    state_d     = state_q;
    capture_c   = 1'b0;
    drop_c      = 1'b0;
    new_fault_c = chk_valid_q & chk_fault_q;
    case (state_q)
      EMPTY: begin
        if (new_fault_c) begin
          state_d   = HELD;
          capture_c = 1'b1;
        end
      end
      HELD: begin
        if (bus.exc_ack) begin
          capture_c = new_fault_c;
          state_d   = new_fault_c ? HELD : EMPTY;
        end else begin
          drop_c = new_fault_c;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin : hold_regs
    if (!reset_n) begin
      exc_code_q     <= '0;
      exc_badvaddr_q <= '0;
      exc_epc_q      <= '0;
      fault_cnt_q    <= '0;
      drop_cnt_q     <= '0;
    end else begin
      if (capture_c) begin
        exc_code_q     <= stg_store_q ? EXC_ADES : EXC_ADEL;
        exc_badvaddr_q <= stg_addr_q;
        exc_epc_q      <= stg_pc_q;
      end
      if (new_fault_c && fault_cnt_q != CNT_MAX) fault_cnt_q <= fault_cnt_q + CNT_W'(1);
      if (drop_c && drop_cnt_q != CNT_MAX)       drop_cnt_q  <= drop_cnt_q + CNT_W'(1);
    end
  end

  assign bus.chk_valid    = chk_valid_q;
  assign bus.chk_fault    = chk_fault_q;
  assign bus.chk_dev      = chk_dev_q;
  assign bus.exc_pending  = state_q;
  assign bus.exc_code     = exc_code_q;
  assign bus.exc_badvaddr = exc_badvaddr_q;
  assign bus.exc_epc      = exc_epc_q;
  assign bus.fault_cnt    = fault_cnt_q;
  assign bus.drop_cnt     = drop_cnt_q;
endmodule

// File: tb/tb_mem_access_guard.sv
// Bench for mem_access_guard with three device windows: vector table, directed
// multi-cycle sequences and random traffic against a behavioural model.
module tb_mem_access_guard;
  localparam int unsigned N_DEV = 3;
  localparam logic [95:0] DEV_BASE = {32'h7F20, 32'h7F10, 32'h7F00};
  localparam int unsigned CNT_W = 8;
  localparam longint DM_LIMIT_L = 64'h2FFF;
  localparam longint SPAN = 12;
  localparam longint RO_OFS = 8;
  localparam int CNT_MAX = 255;

  longint dev_base [N_DEV] = '{64'h7F00, 64'h7F10, 64'h7F20};

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_guard_if #(.CNT_W(CNT_W)) bus ();

  mem_access_guard #(
    .DM_LIMIT(32'h0000_2FFF), .N_DEV(N_DEV), .DEV_BASE(DEV_BASE),
    .DEV_SPAN(12), .DEV_RO_OFS(8), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit          m_valid, m_fault, m_dev, m_store, m_pending;
  logic [31:0] m_addr, m_pc, m_bad, m_epc;
  int          m_code, m_fcnt, m_dcnt;

  typedef struct {
    logic [3:0]  code;
    logic [31:0] addr;
    bit          flush;
    bit          ack;
    bit          ev;
    bit          ef;
    bit          ed;
  } vec_t;
  vec_t vecs [18];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void classify(input logic [3:0] code, input logic [31:0] addr,
                                   output bit acc, output bit flt, output bit dev, output bit st);
    longint a;
    int sz;
    bit dm, hit, ro;
    a = longint'(addr);
    case (code)
      4'd0, 4'd1:       sz = 4;
      4'd2, 4'd4, 4'd6: sz = 2;
      4'd3, 4'd5, 4'd7: sz = 1;
      default:          sz = 0;
    endcase
    st  = (code == 4'd1) || (code == 4'd6) || (code == 4'd7);
    acc = (sz != 0);
    dm  = (sz == 4) ? (a + 3 <= DM_LIMIT_L) : (a <= DM_LIMIT_L);
    hit = 1'b0;
    ro  = 1'b0;
    foreach (dev_base[i]) begin
      if (a >= dev_base[i] && a < dev_base[i] + SPAN) hit = 1'b1;
      if (a == dev_base[i] + RO_OFS) ro = 1'b1;
    end
    if (!acc) flt = 1'b0;
    else flt = ((a % sz) != 0) || (!dm && !hit) || (hit && sz != 4) || (st && ro);
    dev = acc && hit && !flt;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_fault = 0; m_dev = 0; m_store = 0; m_pending = 0;
    m_addr = '0; m_pc = '0; m_bad = '0; m_epc = '0;
    m_code = 0; m_fcnt = 0; m_dcnt = 0;
  endtask

  // One rising edge of the model: resolve the held slot, then accept the new request.
  task automatic model_edge(input bit v, input logic [3:0] code, input logic [31:0] addr,
                            input logic [31:0] pc, input bit fl, input bit ack);
    bit nf, take, acc, flt, dev, st;
    nf = m_valid && m_fault;
    take = 0;
    if (nf) m_fcnt = (m_fcnt < CNT_MAX) ? m_fcnt + 1 : CNT_MAX;
    if (!m_pending || ack) begin
      take = nf;
      m_pending = nf;
    end else if (nf) begin
      m_dcnt = (m_dcnt < CNT_MAX) ? m_dcnt + 1 : CNT_MAX;
    end
    if (take) begin
      m_code = m_store ? 5 : 4;
      m_bad  = m_addr;
      m_epc  = m_pc;
    end
    classify(code, addr, acc, flt, dev, st);
    m_valid = v && acc && !fl;
    m_fault = m_valid && flt;
    m_dev   = m_valid && dev;
    m_store = st;
    m_addr  = addr;
    m_pc    = pc;
  endtask

  task automatic check_all();
    chk("chk_valid",    32'(bus.chk_valid),   32'(m_valid));
    chk("chk_fault",    32'(bus.chk_fault),   32'(m_fault));
    chk("chk_dev",      32'(bus.chk_dev),     32'(m_dev));
    chk("exc_pending",  32'(bus.exc_pending), 32'(m_pending));
    chk("exc_code",     32'(bus.exc_code),    32'(m_code));
    chk("exc_badvaddr", bus.exc_badvaddr,     m_bad);
    chk("exc_epc",      bus.exc_epc,          m_epc);
    chk("fault_cnt",    32'(bus.fault_cnt),   32'(m_fcnt));
    chk("drop_cnt",     32'(bus.drop_cnt),    32'(m_dcnt));
  endtask

  // Called at a falling edge; drives one request, steps the model, checks at the next falling edge.
  task automatic cycle(input bit v, input logic [3:0] code, input logic [31:0] addr,
                       input logic [31:0] pc, input bit fl, input bit ack);
    bus.req_valid = v;
    bus.req_code  = code;
    bus.req_addr  = addr;
    bus.req_pc    = pc;
    bus.flush     = fl;
    bus.exc_ack   = ack;
    @(posedge clk);
    model_edge(v, code, addr, pc, fl, ack);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input bit ack);
    cycle(1'b0, 4'd8, 32'h0, 32'h0, 1'b0, ack);
  endtask

  // Reset asserted between clock edges; outputs must clear before the next edge.
  task automatic do_reset();
    bus.req_valid = 0; bus.req_code = 4'd8; bus.req_addr = '0;
    bus.req_pc = '0; bus.flush = 0; bus.exc_ack = 0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_chk_valid",   32'(bus.chk_valid),   32'd0);
    chk("rst_chk_fault",   32'(bus.chk_fault),   32'd0);
    chk("rst_chk_dev",     32'(bus.chk_dev),     32'd0);
    chk("rst_exc_pending", 32'(bus.exc_pending), 32'd0);
    chk("rst_exc_code",    32'(bus.exc_code),    32'd0);
    chk("rst_badvaddr",    bus.exc_badvaddr,     32'd0);
    chk("rst_epc",         bus.exc_epc,          32'd0);
    chk("rst_fault_cnt",   32'(bus.fault_cnt),   32'd0);
    chk("rst_drop_cnt",    32'(bus.drop_cnt),    32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  logic [31:0] r_addr;
  int          kind;

  initial begin
    vecs[0]  = '{4'd0, 32'h0000_2FFC, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{4'd1, 32'h0000_7F04, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{4'd0, 32'h0000_2FFD, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{4'd0, 32'h0000_7F24, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{4'd0, 32'h0000_7F2C, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{4'd3, 32'h0000_2FFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{4'd2, 32'h0000_3000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{4'd8, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{4'd12, 32'h0000_2FFD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{4'd1, 32'h0000_7F08, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{4'd0, 32'h0000_7F08, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{4'd5, 32'h0000_7F01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{4'd6, 32'h0000_0002, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{4'd0, 32'h0000_2FFD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{4'd4, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[15] = '{4'd0, 32'h0000_7F0C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[16] = '{4'd0, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[17] = '{4'd1, 32'h0000_7F1C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    model_reset();
    @(negedge clk);
    do_reset();

    foreach (vecs[i]) begin
      cycle(1'b1, vecs[i].code, vecs[i].addr, 32'h0040_0000 + 32'(i * 4), vecs[i].flush, vecs[i].ack);
      chk($sformatf("tbl%0d_valid", i), 32'(bus.chk_valid), 32'(vecs[i].ev));
      chk($sformatf("tbl%0d_fault", i), 32'(bus.chk_fault), 32'(vecs[i].ef));
      chk($sformatf("tbl%0d_dev", i),   32'(bus.chk_dev),   32'(vecs[i].ed));
    end
    idle(1'b1);
    idle(1'b0);

    // Back-to-back faults without ack: first held, second dropped.
    do_reset();
    cycle(1'b1, 4'd1, 32'h0000_7F18, 32'h0000_0100, 1'b0, 1'b0);
    cycle(1'b1, 4'd7, 32'h0000_7F00, 32'h0000_0104, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    chk("drop_pending", 32'(bus.exc_pending), 32'd1);
    chk("drop_code",    32'(bus.exc_code),    32'd5);
    chk("drop_bad",     bus.exc_badvaddr,     32'h0000_7F18);
    chk("drop_epc",     bus.exc_epc,          32'h0000_0100);
    chk("drop_dcnt",    32'(bus.drop_cnt),    32'd1);
    chk("drop_fcnt",    32'(bus.fault_cnt),   32'd2);

    // Ack coinciding with a new registered fault replaces the held one.
    do_reset();
    cycle(1'b1, 4'd0, 32'h0000_2FFD, 32'h0000_0200, 1'b0, 1'b0);
    idle(1'b0);
    chk("lw_pending", 32'(bus.exc_pending), 32'd1);
    chk("lw_code",    32'(bus.exc_code),    32'd4);
    chk("lw_bad",     bus.exc_badvaddr,     32'h0000_2FFD);
    chk("lw_epc",     bus.exc_epc,          32'h0000_0200);
    chk("lw_fcnt",    32'(bus.fault_cnt),   32'd1);
    cycle(1'b1, 4'd2, 32'h0000_3000, 32'h0000_0204, 1'b0, 1'b0);
    idle(1'b1);
    chk("ackcap_pending", 32'(bus.exc_pending), 32'd1);
    chk("ackcap_bad",     bus.exc_badvaddr,     32'h0000_3000);
    chk("ackcap_code",    32'(bus.exc_code),    32'd4);
    chk("ackcap_epc",     bus.exc_epc,          32'h0000_0204);
    chk("ackcap_dcnt",    32'(bus.drop_cnt),    32'd0);
    idle(1'b1);
    chk("ack_clear",  32'(bus.exc_pending), 32'd0);
    chk("ack_keep",   bus.exc_badvaddr,     32'h0000_3000);

    // Flushed faulting store leaves no trace.
    do_reset();
    cycle(1'b1, 4'd1, 32'h0000_0003, 32'h0000_0300, 1'b1, 1'b0);
    chk("flush_valid", 32'(bus.chk_valid), 32'd0);
    idle(1'b0);
    chk("flush_pending", 32'(bus.exc_pending), 32'd0);
    chk("flush_fcnt",    32'(bus.fault_cnt),   32'd0);

    // Counter saturation, then asynchronous reset while HELD.
    do_reset();
    for (int i = 0; i < 300; i++)
      cycle(1'b1, 4'd0, 32'h0000_0001, 32'(i), 1'b0, 1'b0);
    idle(1'b0);
    chk("sat_fcnt",    32'(bus.fault_cnt),   32'd255);
    chk("sat_dcnt",    32'(bus.drop_cnt),    32'd255);
    chk("sat_pending", 32'(bus.exc_pending), 32'd1);
    do_reset();

    // Random traffic, biased toward window edges.
    for (int i = 0; i < 3000; i++) begin
      kind = int'($urandom_range(0, 5));
      case (kind)
        0: r_addr = $urandom;
        1: r_addr = 32'h0000_2FF8 + $urandom_range(0, 15);
        2: r_addr = 32'h0000_7F00 + $urandom_range(0, 47);
        3: r_addr = $urandom_range(0, 31);
        4: r_addr = 32'hFFFF_FFF0 + $urandom_range(0, 15);
        default: r_addr = 32'h0000_7EF8 + $urandom_range(0, 63);
      endcase
      cycle($urandom_range(0, 7) != 0, 4'($urandom_range(0, 15)), r_addr, $urandom,
            $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mem_access_guard.md
Name: mem_access_guard

Overview:
- Parametrised, registered successor to the MEM-stage address exception detector.
- Classifies each data-memory access against the DM window and N_DEV device windows, by access size (word/half/byte) and direction (load/store).
- Produces a one-cycle-latency verdict and captures the first faulting access (AdEL/AdES, BadVAddr, EPC) in a holding register until CP0 acknowledges it.
- Sits between the MEM pipeline register and CP0; also keeps a saturating fault counter.

Parameters:
- DM_LIMIT, 32'h0000_2FFF, last byte address of data memory (DM base fixed at 0).
- N_DEV, 2, number of device windows (1..8).
- DEV_BASE, {32'h7F10,32'h7F00}, packed N_DEV*32 base addresses; entry i at bits [32i+31:32i].
- DEV_SPAN, 12, bytes per device window.
- DEV_RO_OFS, 8, byte offset of the read-only register in every device (store there faults).
- CNT_W, 8, width of the fault counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  MEM-stage access present this cycle.
- req_addr  in  32  effective address.
- req_code  in  4  access code: lw 0, sw 1, lh 2, lb 3, lhu 4, lbu 5, sh 6, sb 7, none 8; 9..15 treated as none.
- req_pc  in  32  PC of the accessing instruction.
- flush  in  1  kill the in-flight request (stage flush).
- chk_valid  out  1  verdict valid (registered request).
- chk_fault  out  1  registered request faulted.
- chk_dev  out  1  registered request hit a device window (no fault).
- exc_pending  out  1  holding register occupied.
- exc_code  out  5  ExcCode of the held fault: 4 AdEL, 5 AdES.
- exc_badvaddr  out  32  held faulting address.
- exc_epc  out  32  held faulting PC.
- exc_ack  in  1  CP0 consumed held fault.
- fault_cnt  out  CNT_W  saturating count of faults detected.
- drop_cnt  out  CNT_W  saturating count of faults lost while pending.

Behaviour:
- Reset: every output and internal register is 0.
- Classification (combinational on req_*):
  - Sizes: WORD = codes 0/1; HALF = 2/4/6; BYTE = 3/5/7. Store = 1/6/7; load = 0/2/3/4/5.
  - Address hits: in_dm = addr <= DM_LIMIT-3 for WORD and addr <= DM_LIMIT for HALF/BYTE. in_dev[i] = DEV_BASE[i] <= addr <= DEV_BASE[i]+DEV_SPAN-1, compared in 33 bits, so no wrap past 2^32.
  - Fault if any of the following holds:
    - WORD and addr[1:0] != 0;
    - HALF and addr[0] != 0;
    - address outside both the DM window and every device window;
    - HALF/BYTE access to any device window;
    - store to DEV_BASE[i]+DEV_RO_OFS for any i.
  - Fault code: store faults give 5 (AdES), load faults give 4 (AdEL). Code none never faults and never yields chk_valid.
- Stage register, on each rising clk:
  - chk_valid <= req_valid & is_access & ~flush.
  - chk_fault and chk_dev are registered together with it and read 0 whenever chk_valid is 0.
  - Latency: verdict exactly 1 cycle after the request.
- Holding register, two states, EMPTY and HELD:
  - EMPTY -> HELD: registered fault (chk_valid & chk_fault). Capture code, badvaddr and epc; exc_pending = 1 in the following cycle.
  - HELD -> EMPTY: exc_ack = 1. Captured fields stay readable until overwritten.
  - HELD with a new registered fault and no ack: fault dropped, drop_cnt increments.
  - HELD with ack and a new fault in the same cycle: new fault captured, state stays HELD, no drop.
  - exc_ack in EMPTY is ignored.
- Counters:
  - fault_cnt increments on each registered fault, dropped ones included.
  - Both counters saturate at all-ones; they never wrap.
- flush applies only to the incoming request. It never clears the holding register or the counters.
- reset_n asserted mid-operation clears everything immediately, independent of clk.

Test Plan:
- lw 0x2FFC, then sw 0x7F04 -> chk_valid=1 one cycle later each; chk_fault=0 both; chk_dev=0 then 1; exc_pending stays 0.
- lw 0x2FFD -> chk_fault=1, then exc_pending=1, exc_code=4, exc_badvaddr=0x2FFD, exc_epc=req_pc; fault_cnt=1.
- sw 0x7F18, then sb 0x7F00 back-to-back without ack -> first held with code 5 and badvaddr 0x7F18; second dropped; drop_cnt=1; fault_cnt=2.
- Pending fault plus exc_ack coinciding with registered lh 0x3000 fault -> exc_pending stays 1; badvaddr=0x3000; code=4; drop_cnt unchanged.
- Faulting sw with flush=1 in the same cycle -> chk_valid=0; no capture; counters unchanged. Separately, 300 faults with CNT_W=8 -> fault_cnt=255.
- N_DEV=3 with third base 0x7F20: lw 0x7F24 passes, lw 0x7F2C faults; reset_n pulsed low mid-HELD -> all outputs 0 asynchronously.
